// File: rtl/register_file_param.sv
// ---------------------------------------------------------------------------
// register_file_param
//
// Parameterised register file with two asynchronous read ports, one
// synchronous write port and a non-forwarding debug read port. After
// reset, a hardware clear sequence walks every register. It loads SP_INIT
// into register SP_IDX and zero into all the others. The sequence then hands
// over to normal operation.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high; restarts the clear sequence
//   a1, a2     read addresses; read data appears on rd1, rd2
//   we3        write enable (honoured only once the clear has finished)
//   a3, wd3    write address / write data
//   dbg_sel    debug read address; read data appears on dbg_data (no forwarding)
//   init_busy  high while the clear sequence is running
//
// Register 0 reads as zero on every port. While init_busy is high, all
// read ports drive zero.
// ---------------------------------------------------------------------------
module register_file_param #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter int          SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h7fffefe4,
  parameter int          BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] dbg_data,
  output logic              init_busy
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);
  localparam bit                FWD_EN   = (BYPASS != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fwd1;
  logic              fwd2;
  logic              user_wr;

  // ---- control: clear sequencer ----
  // clr_idx stops on the last index rather than wrapping. READY is entered
  // on the same edge that writes the last register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      init_busy <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_idx == LAST_IDX) begin
        state     <= READY;
        init_busy <= 1'b0;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // ---- write port arbitration: clear sequencer owns the port until READY ----
  assign user_wr = (state == READY) && we3 && (a3 != '0);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_idx;
        wr_data = (clr_idx == SP_ADDR) ? SP_VAL : '0;
      end else if (user_wr) begin
        wr_en   = 1'b1;
        wr_addr = a3;
        wr_data = wd3;
      end
    end
  end

  // Storage has no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // ---- asynchronous read ports ----
  // Forwarding exposes wd3 in the cycle of a write, so rd1/rd2 behave as if
  // the write had already taken effect. The debug port always shows storage.
  assign fwd1 = FWD_EN && user_wr && (a3 == a1);
  assign fwd2 = FWD_EN && user_wr && (a3 == a2);

  always_comb begin
    rd1 = '0;
    if (!init_busy && (a1 != '0)) begin
      rd1 = fwd1 ? wd3 : regs[a1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (!init_busy && (a2 != '0)) begin
      rd2 = fwd2 ? wd3 : regs[a2];
    end
  end

  always_comb begin
    dbg_data = '0;
    if (!init_busy && (dbg_sel != '0)) begin
      dbg_data = regs[dbg_sel];
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

  localparam int NREG = 32;
  localparam logic [31:0] SP_VAL = 32'h7fffefe4;
  localparam int SP = 2;

  logic        clk;
  logic        rst;
  logic [4:0]  a1, a2, a3, dbg_sel;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, dbg_data;
  logic        init_busy;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: architectural register contents plus "clear pending" state.
  logic [31:0] m_regs [NREG];
  bit          m_busy = 1'b1;
  int          m_cnt  = 0;

  register_file_param dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .we3(we3), .a3(a3), .wd3(wd3),
    .dbg_sel(dbg_sel), .rd1(rd1), .rd2(rd2), .dbg_data(dbg_data),
    .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Expected data for a read address given the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd_ok);
    if (m_busy || a == 5'd0) return 32'h0;
    if (fwd_ok && we3 && a3 == a) return wd3;
    return m_regs[a];
  endfunction

  // One clock edge; the model applies the behaviour that edge should have.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == NREG) begin
        for (int i = 0; i < NREG; i++) m_regs[i] = (i == SP) ? SP_VAL : 32'h0;
        m_busy = 1'b0;
      end
    end else if (we3 && a3 != 5'd0) begin
      m_regs[a3] = wd3;
    end
    @(negedge clk);
  endtask

  // Pulse rst for one edge, then count edges until init_busy falls.
  task automatic reset_and_count(output int edges, input bit hold_write);
    rst = 1'b1; we3 = hold_write; tick();
    rst = 1'b0;
    edges = 0;
    while (init_busy === 1'b1 && edges < 100) begin
      #1;
      n_checks++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0 || dbg_data !== 32'h0) begin
        n_fails++;
        $display("FAIL clear_reads_zero: rd1=%h rd2=%h dbg=%h required 0", rd1, rd2, dbg_data);
      end
      tick();
      edges++;
    end
    we3 = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    a1 = 5'd2; a2 = 5'd0; a3 = 5'd0; wd3 = 32'h0; dbg_sel = 5'd0;
    reset_and_count(edges, 1'b0);
    n_checks++;
    if (edges !== NREG) begin
      n_fails++;
      $display("FAIL reset_busy_len: edges=%0d required %0d", edges, NREG);
    end
    a1 = 5'd2; #1;
    n_checks++;
    if (rd1 !== 32'h7fffefe4) begin
      n_fails++;
      $display("FAIL reset_sp: rd1=%h required 7fffefe4", rd1);
    end
    for (int a = 0; a < NREG; a++) begin
      a1 = a[4:0]; a2 = 5'(31 - a); dbg_sel = a[4:0]; #1;
      n_checks++;
      if (rd1 !== exp_rd(a1, 1) || rd2 !== exp_rd(a2, 1) || dbg_data !== exp_rd(dbg_sel, 0)) begin
        n_fails++;
        $display("FAIL reset_contents a=%0d: rd1=%h rd2=%h dbg=%h required %h %h %h",
                 a, rd1, rd2, dbg_data, exp_rd(a1, 1), exp_rd(a2, 1), exp_rd(dbg_sel, 0));
      end
    end
  endtask

  task automatic test_bypass();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; a1 = 5'd5; a2 = 5'd5; dbg_sel = 5'd5; #1;
    n_checks++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF) begin
      n_fails++;
      $display("FAIL bypass_same_cycle: rd1=%h rd2=%h required deadbeef", rd1, rd2);
    end
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_fails++;
      $display("FAIL bypass_dbg_no_fwd: dbg=%h required 0", dbg_data);
    end
    tick();
    we3 = 1'b0; #1;
    n_checks++;
    if (rd1 !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF) begin
      n_fails++;
      $display("FAIL bypass_next_cycle: rd1=%h dbg=%h required deadbeef", rd1, dbg_data);
    end
  endtask

  task automatic test_zero_write();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a1 = 5'd0; a2 = 5'd0; dbg_sel = 5'd0; #1;
    n_checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      n_fails++;
      $display("FAIL zero_write_same: rd1=%h rd2=%h required 0", rd1, rd2);
    end
    tick();
    we3 = 1'b0; #1;
    n_checks++;
    if (rd1 !== 32'h0 || dbg_data !== 32'h0) begin
      n_fails++;
      $display("FAIL zero_write_after: rd1=%h dbg=%h required 0", rd1, dbg_data);
    end
  endtask

  task automatic test_write_during_clear();
    int edges;
    a3 = 5'd7; wd3 = 32'h12345678; a1 = 5'd7; a2 = 5'd2; dbg_sel = 5'd7;
    reset_and_count(edges, 1'b1);
    n_checks++;
    if (edges !== NREG) begin
      n_fails++;
      $display("FAIL clear_write_len: edges=%0d required %0d", edges, NREG);
    end
    #1;
    n_checks++;
    if (rd1 !== 32'h0 || dbg_data !== 32'h0 || rd2 !== 32'h7fffefe4) begin
      n_fails++;
      $display("FAIL clear_write_ignored: rd1=%h dbg=%h rd2=%h required 0 0 7fffefe4", rd1, dbg_data, rd2);
    end
  endtask

  task automatic test_reset_mid_clear();
    int edges;
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'hA5A5A5A5; tick();
    we3 = 1'b0; a1 = 5'd9; #1;
    n_checks++;
    if (rd1 !== 32'hA5A5A5A5) begin
      n_fails++;
      $display("FAIL midclr_prewrite: rd1=%h required a5a5a5a5", rd1);
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (init_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL midclr_busy: init_busy=%b required 1", init_busy);
    end
    reset_and_count(edges, 1'b0);
    n_checks++;
    if (edges !== NREG) begin
      n_fails++;
      $display("FAIL midclr_len: edges=%0d required %0d", edges, NREG);
    end
    a1 = 5'd9; a2 = 5'd2; #1;
    n_checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h7fffefe4) begin
      n_fails++;
      $display("FAIL midclr_contents: rd1=%h rd2=%h required 0 7fffefe4", rd1, rd2);
    end
  endtask

  task automatic test_debug();
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h00000042; tick();
    we3 = 1'b0; dbg_sel = 5'd9; #1;
    n_checks++;
    if (dbg_data !== 32'h00000042) begin
      n_fails++;
      $display("FAIL dbg_read: dbg=%h required 00000042", dbg_data);
    end
    we3 = 1'b1; wd3 = 32'h1; a1 = 5'd9; #1;
    n_checks++;
    if (dbg_data !== 32'h00000042 || rd1 !== 32'h1) begin
      n_fails++;
      $display("FAIL dbg_concurrent: dbg=%h rd1=%h required 00000042 00000001", dbg_data, rd1);
    end
    tick();
    we3 = 1'b0; #1;
    n_checks++;
    if (dbg_data !== 32'h1) begin
      n_fails++;
      $display("FAIL dbg_after_edge: dbg=%h required 00000001", dbg_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we3 = ($urandom_range(0, 2) != 0);
      a3  = 5'($urandom_range(0, 31));
      wd3 = $urandom;
      a1  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      dbg_sel = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
      #1;
      n_checks++;
      if (rd1 !== exp_rd(a1, 1) || rd2 !== exp_rd(a2, 1) || dbg_data !== exp_rd(dbg_sel, 0)
          || init_busy !== m_busy) begin
        n_fails++;
        $display("FAIL random n=%0d: rd1=%h rd2=%h dbg=%h busy=%b required %h %h %h %b",
                 n, rd1, rd2, dbg_data, init_busy,
                 exp_rd(a1, 1), exp_rd(a2, 1), exp_rd(dbg_sel, 0), m_busy);
      end
      if (a1 == a2) begin
        n_checks++;
        if (rd1 !== rd2) begin
          n_fails++;
          $display("FAIL same_addr n=%0d: rd1=%h rd2=%h required equal", n, rd1, rd2);
        end
      end
      tick();
    end
    we3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; dbg_sel = '0;
    @(negedge clk);
    tick();
    test_reset();
    test_bypass();
    test_zero_write();
    test_random();
    test_write_during_clear();
    test_reset_mid_clear();
    test_debug();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5; register count NUM_REGS = 2^ADDR_W.
REQ-003 SHALL have parameter SP_IDX, default 2, index of the register given a non-zero initial value.
REQ-004 SHALL have parameter SP_INIT, default 32'h7fffefe4, initial value of register SP_IDX (truncated/zero-extended to DATA_W).
REQ-005 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-006 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have ports a1, a2, input, ADDR_W, read addresses for ports 1 and 2.
REQ-009 SHALL have port we3, input, 1, write enable.
REQ-010 SHALL have port a3, input, ADDR_W, write address.
REQ-011 SHALL have port wd3, input, DATA_W, write data.
REQ-012 SHALL have port dbg_sel, input, ADDR_W, debug read address.
REQ-013 SHALL have ports rd1, rd2, output, DATA_W, read data for a1 and a2.
REQ-014 SHALL have port dbg_data, output, DATA_W, read data for dbg_sel (no bypass).
REQ-015 SHALL have port init_busy, output, 1, high while the clear sequence runs.

Function
REQ-016 SHALL hold NUM_REGS x DATA_W storage; register 0 SHALL always read 0 on every read port regardless of stored content.
REQ-017 SHALL implement a two-state FSM: CLEAR and READY.
REQ-018 In CLEAR, at each rising edge with rst=0, SHALL write index clr_idx with SP_INIT if clr_idx==SP_IDX else 0, then increment clr_idx.
REQ-019 The edge that writes clr_idx==NUM_REGS-1 SHALL move the FSM to READY; clr_idx SHALL NOT wrap within CLEAR.
REQ-020 init_busy SHALL equal 1 in CLEAR and 0 in READY (registered, no combinational path from inputs).
REQ-021 In READY, a rising edge with we3=1 and a3!=0 SHALL write wd3 to register a3; a3==0 writes SHALL be discarded.
REQ-022 we3 SHALL be ignored in CLEAR (no user write lands during or is deferred past the clear).
REQ-023 Reads SHALL be asynchronous (combinational from a1/a2/dbg_sel and storage), zero cycles latency.
REQ-024 While init_busy=1, rd1, rd2 and dbg_data SHALL drive 0.
REQ-025 If BYPASS=1, in READY, with we3=1, a3!=0 and a3==a1, rd1 SHALL equal wd3 in the same cycle; likewise rd2 for a2.
REQ-026 If BYPASS=0, rd1/rd2 SHALL show the pre-write value until the write edge.
REQ-027 Simultaneous a1==a2 SHALL return identical data on both ports.

Reset
REQ-028 A rising edge with rst=1 SHALL set FSM=CLEAR, clr_idx=0, init_busy=1, regardless of current state (including mid-clear).
REQ-029 While rst stays high, clr_idx SHALL hold at 0 and no storage writes SHALL occur.
REQ-030 After rst deasserts, init_busy SHALL fall after exactly NUM_REGS rising edges (32 at defaults).
REQ-031 Storage and FSM power-up values SHALL be undefined; rst is required before use.

Verification
REQ-032 Pulse rst 1 cycle -> init_busy=1 for 32 edges, rd1=0 meanwhile; then a1=2 -> rd1=32'h7fffefe4, a1=1..31 (except 2) -> 0.
REQ-033 READY, we3=1 a3=5 wd3=32'hDEADBEEF, a1=5 same cycle -> rd1=32'hDEADBEEF (BYPASS=1) / old value 0 (BYPASS=0); next cycle rd1=32'hDEADBEEF both builds.
REQ-034 we3=1 a3=0 wd3=32'hFFFFFFFF -> rd1 with a1=0 reads 0, same cycle and after.
REQ-035 During CLEAR, we3=1 a3=7 wd3=32'h12345678 -> after init_busy falls, register 7 reads 0.
REQ-036 Write reg 9=32'hA5A5A5A5, then rst pulse at clr_idx=10 of a later clear -> clear restarts at 0, init_busy falls 32 edges after deassert, reg 9 reads 0.
REQ-037 dbg_sel=9 after writing reg 9=32'h00000042 -> dbg_data=32'h00000042; dbg_sel=9 with concurrent write of 32'h1 -> dbg_data stays 32'h00000042 until the edge.
